// File: rtl/error_angle_counter.sv
// error_angle_counter
// Signed, saturating up/down error counter fed by the CDU error-angle stage.
// Each falling edge of the synchronised _TPS timing pulse is a tick; on a tick
// the synchronised _UPLVL/_DNLVL levels request one count step up or down.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   _UPLVL     count-up request, active-low, asynchronous
//   _DNLVL     count-down request, active-low, asynchronous
//   _TPS       count-timing pulse, active-low, asynchronous
//   ERREN      counter enable, active-high, synchronous
//   ERRZRO     counter clear, active-high, synchronous
//   err_count  signed error count (two's complement, WIDTH bits)
//   at_limit   high while err_count is at +LIMIT or -LIMIT
//   dual_fault sticky flag: up and down both requested at a tick
//   cnt_pulse  one-cycle strobe for each actual change of err_count
//   cnt_dir    direction of the last change (1 = up, 0 = down)
module error_angle_counter #(
   parameter int unsigned WIDTH       = 10,
   parameter int unsigned LIMIT       = 384,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    _UPLVL,
   input  logic                    _DNLVL,
   input  logic                    _TPS,
   input  logic                    ERREN,
   input  logic                    ERRZRO,
   output logic signed [WIDTH-1:0] err_count,
   output logic                    at_limit,
   output logic                    dual_fault,
   output logic                    cnt_pulse,
   output logic                    cnt_dir
);

   localparam logic signed [WIDTH-1:0] POS_LIMIT = WIDTH'(LIMIT);
   localparam logic signed [WIDTH-1:0] NEG_LIMIT = -POS_LIMIT;
   localparam logic signed [WIDTH-1:0] ONE       = WIDTH'(1);

   typedef enum logic [1:0] {StOff, StIdle, StStep} state_e;

   // Synchronisers: bit 0 takes the raw input, the MSB is the synced level.
   logic [SYNC_STAGES-1:0] up_sync_q;
   logic [SYNC_STAGES-1:0] dn_sync_q;
   logic [SYNC_STAGES-1:0] tps_sync_q;
   logic                   tps_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_sync_q  <= '1;
         dn_sync_q  <= '1;
         tps_sync_q <= '1;
         tps_prev_q <= 1'b1;
      end else begin
         up_sync_q  <= {up_sync_q[SYNC_STAGES-2:0], _UPLVL};
         dn_sync_q  <= {dn_sync_q[SYNC_STAGES-2:0], _DNLVL};
         tps_sync_q <= {tps_sync_q[SYNC_STAGES-2:0], _TPS};
         tps_prev_q <= tps_sync_q[SYNC_STAGES-1];
      end
   end

   logic tick;
   logic up_req;
   logic dn_req;

   assign tick   = tps_prev_q & ~tps_sync_q[SYNC_STAGES-1];
   assign up_req = ~up_sync_q[SYNC_STAGES-1];
   assign dn_req = ~dn_sync_q[SYNC_STAGES-1];

   state_e                  state_q, state_d;
   logic signed [WIDTH-1:0] count_q, count_d;
   logic                    step_up_q, step_up_d;  // direction latched at the tick
   logic                    at_limit_q, at_limit_d;
   logic                    fault_q, fault_d;
   logic                    pulse_q, pulse_d;
   logic                    dir_q, dir_d;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      step_up_d = step_up_q;
      fault_d   = fault_q;
      pulse_d   = 1'b0;
      dir_d     = dir_q;

      if (ERRZRO) begin
         count_d = '0;
         fault_d = 1'b0;
         state_d = ERREN ? StIdle : StOff;
      end else if (!ERREN) begin
         count_d = '0;
         state_d = StOff;
      end else begin
         unique case (state_q)
            StOff: begin
               state_d = StIdle;
            end
            StIdle: begin
               if (tick) begin
                  if (up_req ^ dn_req) begin
                     step_up_d = up_req;
                     state_d   = StStep;
                  end else if (up_req && dn_req) begin
                     fault_d = 1'b1;
                  end
               end
            end
            StStep: begin
               // Any tick seen here is deliberately ignored.
               state_d = StIdle;
               if (step_up_q) begin
                  if (count_q != POS_LIMIT) begin
                     count_d = count_q + ONE;
                     pulse_d = 1'b1;
                     dir_d   = 1'b1;
                  end
               end else begin
                  if (count_q != NEG_LIMIT) begin
                     count_d = count_q - ONE;
                     pulse_d = 1'b1;
                     dir_d   = 1'b0;
                  end
               end
            end
            default: begin
               state_d = StOff;
            end
         endcase
      end

      // Derived from the next count so the registered flag never lags it.
      at_limit_d = (count_d == POS_LIMIT) || (count_d == NEG_LIMIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StOff;
         count_q    <= '0;
         step_up_q  <= 1'b0;
         at_limit_q <= 1'b0;
         fault_q    <= 1'b0;
         pulse_q    <= 1'b0;
         dir_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         step_up_q  <= step_up_d;
         at_limit_q <= at_limit_d;
         fault_q    <= fault_d;
         pulse_q    <= pulse_d;
         dir_q      <= dir_d;
      end
   end

   assign err_count  = count_q;
   assign at_limit   = at_limit_q;
   assign dual_fault = fault_q;
   assign cnt_pulse  = pulse_q;
   assign cnt_dir    = dir_q;

endmodule

// File: tb/tb_error_angle_counter.sv
module tb_error_angle_counter;

   localparam int WIDTH = 10;
   localparam int LIMIT = 384;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    up_n = 1'b1;
   logic                    dn_n = 1'b1;
   logic                    tps_n = 1'b1;
   logic                    erren = 1'b0;
   logic                    errzro = 1'b0;
   logic signed [WIDTH-1:0] err_count;
   logic                    at_limit;
   logic                    dual_fault;
   logic                    cnt_pulse;
   logic                    cnt_dir;

   error_angle_counter #(
      .WIDTH      (WIDTH),
      .LIMIT      (LIMIT),
      .SYNC_STAGES(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      ._UPLVL    (up_n),
      ._DNLVL    (dn_n),
      ._TPS      (tps_n),
      .ERREN     (erren),
      .ERRZRO    (errzro),
      .err_count (err_count),
      .at_limit  (at_limit),
      .dual_fault(dual_fault),
      .cnt_pulse (cnt_pulse),
      .cnt_dir   (cnt_dir)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Scoreboard entry: value and direction after a change, and the cycle it must appear.
   typedef struct {
      int cnt;
      int dir;
      int cyc;
   } exp_t;
   exp_t sb_q[$];

   // Reference model state
   bit m_en    = 1'b0;
   int m_cnt   = 0;

   int pulse_total   = 0;
   bit relaxed       = 1'b0;
   int relaxed_count = 0;

   always @(negedge clk) begin
      if (cnt_pulse === 1'b1) begin
         pulse_total++;
         if (relaxed) begin
            relaxed_count++;
         end else begin
            check("sb_pending", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_count", int'(err_count), e.cnt);
               check("sb_dir", int'(cnt_dir), e.dir);
               check("sb_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // Called at a negedge when _TPS is driven low; edge N is the next posedge.
   task automatic model_tick(input bit u, input bit d);
      exp_t e;
      if (m_en && (u ^ d)) begin
         if (u && m_cnt < LIMIT) begin
            m_cnt++;
            e.cnt = m_cnt; e.dir = 1; e.cyc = cyc + 4;
            sb_q.push_back(e);
         end else if (d && m_cnt > -LIMIT) begin
            m_cnt--;
            e.cnt = m_cnt; e.dir = 0; e.cyc = cyc + 4;
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic tps_pulse();
      model_tick(!up_n, !dn_n);
      tps_n = 1'b0;
      repeat (2) @(negedge clk);
      tps_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic set_levels(input bit u_n, input bit d_n);
      up_n = u_n;
      dn_n = d_n;
      repeat (2) @(negedge clk);
   endtask

   task automatic drain();
      repeat (6) @(negedge clk);
   endtask

   task automatic clear_pulse();
      errzro = 1'b1;
      @(negedge clk);
      errzro = 1'b0;
      m_cnt = 0;
   endtask

   initial begin
      int p0;
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_count", int'(err_count), 0);
      check("rst_at_limit", int'(at_limit), 0);
      check("rst_fault", int'(dual_fault), 0);
      check("rst_pulse", int'(cnt_pulse), 0);
      check("rst_dir", int'(cnt_dir), 0);
      rst = 1'b0;
      @(negedge clk);

      // Five up ticks
      erren = 1'b1;
      m_en  = 1'b1;
      set_levels(1'b0, 1'b1);
      p0 = pulse_total;
      repeat (5) tps_pulse();
      drain();
      check("up5_count", int'(err_count), 5);
      check("up5_pulses", pulse_total - p0, 5);
      check("up5_dir", int'(cnt_dir), 1);
      check("up5_at_limit", int'(at_limit), 0);

      // Saturate at -LIMIT
      clear_pulse();
      @(negedge clk);
      check("clr_count", int'(err_count), 0);
      set_levels(1'b1, 1'b0);
      p0 = pulse_total;
      repeat (390) tps_pulse();
      drain();
      check("sat_count", int'(err_count), -LIMIT);
      check("sat_at_limit", int'(at_limit), 1);
      check("sat_pulses", pulse_total - p0, LIMIT);
      check("sat_dir", int'(cnt_dir), 0);
      set_levels(1'b0, 1'b1);
      tps_pulse();
      drain();
      check("unsat_count", int'(err_count), -LIMIT + 1);
      check("unsat_at_limit", int'(at_limit), 0);
      check("unsat_dir", int'(cnt_dir), 1);

      // Dual request fault
      set_levels(1'b0, 1'b0);
      tps_pulse();
      drain();
      check("dual_fault_set", int'(dual_fault), 1);
      check("dual_count", int'(err_count), -LIMIT + 1);
      set_levels(1'b1, 1'b1);
      tps_pulse();
      drain();
      check("dual_sticky", int'(dual_fault), 1);
      check("idle_count", int'(err_count), -LIMIT + 1);
      clear_pulse();
      @(negedge clk);
      check("dual_cleared", int'(dual_fault), 0);
      check("dual_clr_count", int'(err_count), 0);

      // ERRZRO during STEP abandons the pending change
      set_levels(1'b0, 1'b1);
      repeat (10) tps_pulse();
      drain();
      check("ten_count", int'(err_count), 10);
      tps_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tps_n = 1'b1;
      @(negedge clk);
      errzro = 1'b1;               // sampled at the edge ending the STEP cycle
      @(negedge clk);
      errzro = 1'b0;
      m_cnt  = 0;
      check("zro_step_pulse", int'(cnt_pulse), 0);
      check("zro_step_count", int'(err_count), 0);
      check("zro_step_dir", int'(cnt_dir), 1);
      drain();
      check("zro_step_later", int'(err_count), 0);

      // Disabled counter ignores ticks
      erren = 1'b0;
      m_en  = 1'b0;
      repeat (2) @(negedge clk);
      repeat (4) tps_pulse();
      drain();
      check("off_count", int'(err_count), 0);
      erren = 1'b1;
      m_en  = 1'b1;
      @(negedge clk);
      tps_pulse();
      drain();
      check("en_count", int'(err_count), 1);
      set_levels(1'b0, 1'b0);
      tps_pulse();
      drain();
      check("en_fault", int'(dual_fault), 1);
      erren = 1'b0;
      m_en  = 1'b0;
      @(negedge clk);
      check("dis_count", int'(err_count), 0);
      check("dis_fault_kept", int'(dual_fault), 1);
      check("dis_at_limit", int'(at_limit), 0);
      clear_pulse();
      @(negedge clk);
      check("dis_fault_clr", int'(dual_fault), 0);

      // Falls two cycles apart: the second may be dropped, never more than two steps
      erren = 1'b1;
      m_en  = 1'b1;
      set_levels(1'b0, 1'b1);
      relaxed       = 1'b1;
      relaxed_count = 0;
      tps_n = 1'b0;
      @(negedge clk);
      tps_n = 1'b1;
      @(negedge clk);
      tps_n = 1'b0;
      @(negedge clk);
      tps_n = 1'b1;
      repeat (3) @(negedge clk);
      drain();
      relaxed = 1'b0;
      check("close_pulses_ok", int'(relaxed_count == 1 || relaxed_count == 2), 1);
      check("close_count", int'(err_count), relaxed_count);
      clear_pulse();
      @(negedge clk);
      check("close_clr", int'(err_count), 0);

      // Reset in the middle of a STEP
      tps_pulse();
      drain();
      check("pre_rst_count", int'(err_count), 1);
      set_levels(1'b0, 1'b0);
      tps_pulse();
      drain();
      set_levels(1'b0, 1'b1);
      tps_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tps_n = 1'b1;
      @(negedge clk);
      rst  = 1'b1;
      m_en = 1'b0;
      #1;
      check("arst_count", int'(err_count), 0);
      check("arst_at_limit", int'(at_limit), 0);
      check("arst_fault", int'(dual_fault), 0);
      check("arst_pulse", int'(cnt_pulse), 0);
      check("arst_dir", int'(cnt_dir), 0);
      @(negedge clk);
      check("arst_hold_pulse", int'(cnt_pulse), 0);
      check("arst_hold_count", int'(err_count), 0);
      rst = 1'b0;
      drain();
      check("sb_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
